// File: rtl/onehot_decoder_3_5.sv
`default_nettype none
// ============================================================================
// Module   : onehot_decoder_3_5
// Brief    : Registered, flow-controlled 3-to-5 binary-to-one-hot decoder with
//            a 2-entry input buffer and a programmable per-word hold time.
// Revision : 1.0 - initial release
// ============================================================================
module onehot_decoder_3_5 #(
    parameter int unsigned HOLD = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] in_code,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [4:0] onehot_out,
    output logic       out_valid,
    output logic       busy,
    output logic       err_code,
    input  logic       err_clr
);

    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_DRIVE  = 1'b1;
    localparam logic [3:0] c_HOLD_LAST = 4'(HOLD - 1);
    localparam logic [2:0] c_MAX_CODE  = 3'd4;
    localparam logic [1:0] c_OCC_FULL  = 2'd2;

    logic [0:0] r_state;
    logic [3:0] r_count;
    logic [4:0] r_onehot;
    logic       r_err;

    logic [2:0] r_mem [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_occ;

    logic       w_ready;
    logic       w_accept;
    logic       w_legal;
    logic       w_push;
    logic       w_illegal;
    logic       w_hold_done;
    logic       w_pop;
    logic [2:0] w_head;
    logic [4:0] w_head_onehot;

    // Ready comes only from registered occupancy, so a pop frees a slot one cycle later.
    assign w_ready       = (r_occ != c_OCC_FULL);
    assign w_accept      = in_valid & w_ready;
    assign w_legal       = (in_code <= c_MAX_CODE);
    assign w_push        = w_accept & w_legal;
    assign w_illegal     = w_accept & ~w_legal;
    assign w_hold_done   = (r_count == c_HOLD_LAST);
    assign w_pop         = (r_occ != 2'd0) &&
                           ((r_state == c_ST_IDLE) || w_hold_done);
    assign w_head        = r_mem[r_rd_ptr];
    assign w_head_onehot = 5'b00001 << w_head;

    // Storage array carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_code;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= c_ST_IDLE;
            r_count  <= 4'd0;
            r_onehot <= 5'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_pop) begin
                        r_onehot <= w_head_onehot;
                        r_count  <= 4'd0;
                        r_state  <= c_ST_DRIVE;
                    end
                end
                c_ST_DRIVE: begin
                    if (w_hold_done) begin
                        r_count <= 4'd0;
                        if (w_pop) begin
                            r_onehot <= w_head_onehot;
                        end else begin
                            r_onehot <= 5'd0;
                            r_state  <= c_ST_IDLE;
                        end
                    end else begin
                        r_count <= r_count + 4'd1;
                    end
                end
                default: begin
                    r_state  <= c_ST_IDLE;
                    r_count  <= 4'd0;
                    r_onehot <= 5'd0;
                end
            endcase
        end
    end

    // A new illegal code outranks a clear arriving in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (w_illegal) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign in_ready   = w_ready;
    assign onehot_out = r_onehot;
    assign out_valid  = (r_state == c_ST_DRIVE);
    assign busy       = (r_state == c_ST_DRIVE) || (r_occ != 2'd0);
    assign err_code   = r_err;

endmodule
`default_nettype wire
